elastic_pipeline: RTL and testbench
===================================

ELASTIC_PIPELINE -- requirements
Module: elastic_pipeline

Interface
REQ-001 SHALL have parameter STAGES, default 3, number of register stages (legal >= 1).
REQ-002 SHALL have parameter WIDTH, default 8, payload bits per stage (legal >= 1).
REQ-003 SHALL have parameter CW, default $clog2(STAGES+1), occupancy counter width.
REQ-004 SHALL have port clk_in  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n_in  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush_in  input  1  synchronous clear of all stage valid bits.
REQ-007 SHALL have port in_valid_in  input  1  upstream word present.
REQ-008 SHALL have port in_data_in  input  WIDTH  upstream payload.
REQ-009 SHALL have port in_ready_out  output  1  pipeline accepts a word this cycle.
REQ-010 SHALL have port out_valid_out  output  1  last stage holds a valid word.
REQ-011 SHALL have port out_data_out  output  WIDTH  last-stage payload.
REQ-012 SHALL have port out_ready_in  input  1  downstream accepts a word.
REQ-013 SHALL have port occupancy_out  output  CW  count of valid stages, 0..STAGES.

Function
REQ-014 SHALL hold per stage i (0..STAGES-1) a valid bit v[i] and a WIDTH-bit data register d[i]; stage STAGES-1 drives out_valid_out/out_data_out directly (registered outputs).
REQ-015 SHALL define advance for the last stage as adv[STAGES-1] = v[STAGES-1] & out_ready_in.
REQ-016 SHALL define stage i ready as rdy[i] = ~v[i] | adv[i]; for i < STAGES-1, adv[i] = v[i] & rdy[i+1] (bubble collapsing: a word moves into any empty downstream stage even when the output is stalled).
REQ-017 SHALL drive in_ready_out = rdy[0] & ~flush_in; a transfer occurs when in_valid_in & in_ready_out.
REQ-018 SHALL, on a transfer into stage i, load d[i] from the upstream source and set v[i]; when stage i advances without being refilled, clear v[i]; d[i] SHALL hold while v[i] is set and stage i does not advance.
REQ-019 SHALL give latency exactly STAGES cycles from input transfer to out_valid_out with no stall; throughput one word per cycle while out_ready_in is high.
REQ-020 SHALL preserve order and never drop or duplicate a word; payload SHALL be unchanged end to end.
REQ-021 SHALL, when flush_in is high, clear all v[i] at the next edge, accept no input that cycle, and ignore out_ready_in for counting purposes; a word presented with out_valid_out & out_ready_in in the flush cycle still counts as delivered.
REQ-022 SHALL keep occupancy_out registered, equal to the number of set v[i]; +1 on input transfer, -1 on output transfer, unchanged on both, 0 after flush.
REQ-023 SHALL keep out_data_out stable while out_valid_out is high and out_ready_in is low.
REQ-024 SHALL, when full (occupancy = STAGES) and out_ready_in high, accept a new input the same cycle (in_ready_out high through the combinational ready chain).
REQ-025 SHALL, for STAGES = 1, behave as a single full-throughput register slice.

Reset
REQ-026 SHALL, on rst_n_in low, asynchronously clear all v[i], all d[i], and occupancy; out_valid_out = 0, out_data_out = 0, occupancy_out = 0; in_ready_out = 1 once flush_in is low.
REQ-027 SHALL, on reset assertion mid-operation, discard all in-flight words; first accept occurs on the first edge after rst_n_in deasserts.

Structure
REQ-028 SHALL place the occupancy-width helper function and handshake-transfer typedef (valid, data) in shared package pipeline_pkg.
REQ-029 SHALL instantiate one sub-module pipe_stage per stage (valid/data register with load/advance controls), generated with a generate loop.

Verification (STAGES=3, WIDTH=8)
REQ-030 SHALL check streaming: 0x01..0x06 back-to-back, out_ready_in=1 -> 0x01 at output on cycle 3, one word per cycle, occupancy steady at 3.
REQ-031 SHALL check stall/collapse: push 0x11, 0x22 with gap, out_ready_in=0 -> words pack into stages 2,1; occupancy 2; in_ready_out stays 1 until occupancy 3.
REQ-032 SHALL check full-with-drain: full pipe (0xA0,0xA1,0xA2), out_ready_in=1 and in_valid 0xA3 same cycle -> 0xA0 delivered, 0xA3 accepted, occupancy stays 3.
REQ-033 SHALL check flush: occupancy 2 plus in_valid 0x55 during flush_in -> in_ready_out=0, next cycle out_valid_out=0, occupancy 0, 0x55 never appears.
REQ-034 SHALL check async reset mid-stream: rst_n_in low between edges -> outputs zero immediately; after release, 0x7E emerges after 3 cycles.
REQ-035 SHALL check random valid/ready scoreboard: 10k words, order and data intact, occupancy never exceeds 3.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and helpers for the elastic pipeline slice.
package pipeline_pkg;

  localparam int XFER_W = 8;

  // One handshake beat as seen on either side of the pipeline.
  typedef struct packed {
    logic              valid;
    logic [XFER_W-1:0] data;
  } xfer_t;

  function automatic int occ_width(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/elastic_pipeline_if.sv
// Valid/ready/data handshake bundle for attaching producers and consumers.
interface elastic_pipeline_if #(
  parameter int WIDTH = 8
);

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_stage.sv
// One elastic stage: valid bit plus payload register with load/advance control.
module pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             flush,
  input  logic             load,
  input  logic             adv,
  input  logic [WIDTH-1:0] d_nxt,
  output logic             vld,
  output logic [WIDTH-1:0] data
);

  // Load wins over advance so a stage refilled in the same cycle stays valid.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vld  <= 1'b0;
      data <= '0;
    end else begin
      if (flush)     vld <= 1'b0;
      else if (load) vld <= 1'b1;
      else if (adv)  vld <= 1'b0;
      if (load) data <= d_nxt;
    end
  end

endmodule

// File: rtl/elastic_pipeline.sv
// Elastic valid/ready pipeline with bubble collapsing, flush and occupancy count.
module elastic_pipeline
  import pipeline_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int WIDTH  = 8,
  parameter int CW     = occ_width(STAGES)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             flush_in,
  input  logic             in_valid_in,
  input  logic [WIDTH-1:0] in_data_in,
  output logic             in_ready_out,
  output logic             out_valid_out,
  output logic [WIDTH-1:0] out_data_out,
  input  logic             out_ready_in,
  output logic [CW-1:0]    occupancy_out
);

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] rdy;
  logic [WIDTH-1:0]  data [STAGES];
  logic              in_xfer;
  logic              out_xfer;
  logic [CW-1:0]     occ_q;

  // Ready ripples back from the output so a full pipe can drain and refill in one cycle.
  always_comb begin
    adv = '0;
    rdy = '0;
    adv[STAGES-1] = vld[STAGES-1] & out_ready_in;
    rdy[STAGES-1] = ~vld[STAGES-1] | adv[STAGES-1];
    for (int i = STAGES - 2; i >= 0; i--) begin
      adv[i] = vld[i] & rdy[i+1];
      rdy[i] = ~vld[i] | adv[i];
    end
  end

  assign in_ready_out = rdy[0] & ~flush_in;
  assign in_xfer      = in_valid_in & in_ready_out;
  assign out_xfer     = vld[STAGES-1] & out_ready_in;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             load;
    logic [WIDTH-1:0] src;
    if (i == 0) begin : g_head
      assign load = in_xfer;
      assign src  = in_data_in;
    end else begin : g_body
      assign load = adv[i-1];
      assign src  = data[i-1];
    end
    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .flush    (flush_in),
      .load     (load),
      .adv      (adv[i]),
      .d_nxt    (src),
      .vld      (vld[i]),
      .data     (data[i])
    );
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)                occ_q <= '0;
    else if (flush_in)            occ_q <= '0;
    else if (in_xfer && !out_xfer) occ_q <= occ_q + CW'(1);
    else if (!in_xfer && out_xfer) occ_q <= occ_q - CW'(1);
  end

  assign out_valid_out = vld[STAGES-1];
  assign out_data_out  = data[STAGES-1];
  assign occupancy_out = occ_q;

endmodule

// File: tb/tb_elastic_pipeline.sv
// Directed and scoreboarded checks of elastic_pipeline at STAGES=3, WIDTH=8.
module tb_elastic_pipeline;
  import pipeline_pkg::*;

  localparam int STAGES = 3;
  localparam int WIDTH  = 8;
  localparam int CW     = occ_width(STAGES);

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          flush_in;
  logic [CW-1:0] occ;
  int            n_checks = 0;
  int            n_fail   = 0;

  elastic_pipeline_if #(.WIDTH(WIDTH)) up_if ();
  elastic_pipeline_if #(.WIDTH(WIDTH)) dn_if ();

  always #5 clk_in = ~clk_in;

  elastic_pipeline #(.STAGES(STAGES), .WIDTH(WIDTH), .CW(CW)) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .flush_in      (flush_in),
    .in_valid_in   (up_if.valid),
    .in_data_in    (up_if.data),
    .in_ready_out  (up_if.ready),
    .out_valid_out (dn_if.valid),
    .out_data_out  (dn_if.data),
    .out_ready_in  (dn_if.ready),
    .occupancy_out (occ)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0; flush_in = 1'b0;
    up_if.valid = 1'b0; up_if.data = '0; dn_if.ready = 1'b0;
    #12;
    n_checks++; if (dn_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", dn_if.valid); end
    n_checks++; if (dn_if.data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", dn_if.data); end
    n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occ); end
    n_checks++; if (up_if.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", up_if.ready); end
    rst_n_in = 1'b1;
    tick();
  endtask

  task automatic test_streaming();
    logic exp_v;
    dn_if.ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      up_if.valid = (c < 6);
      up_if.data  = 8'(c + 1);
      #1;
      exp_v = (c >= 3) && (c < 9);
      if (c < 6) begin
        n_checks++; if (up_if.ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready c=%0d: got %b want 1", c, up_if.ready); end
      end
      n_checks++; if (dn_if.valid !== exp_v) begin n_fail++; $display("FAIL stream_valid c=%0d: got %b want %b", c, dn_if.valid, exp_v); end
      if (exp_v) begin
        n_checks++; if (dn_if.data !== 8'(c - 2)) begin n_fail++; $display("FAIL stream_data c=%0d: got %h want %h", c, dn_if.data, 8'(c - 2)); end
      end
      if (c >= 3 && c <= 6) begin
        n_checks++; if (occ !== 2'd3) begin n_fail++; $display("FAIL stream_occ c=%0d: got %0d want 3", c, occ); end
      end
      tick();
    end
    up_if.valid = 1'b0;
    n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL stream_occ_end: got %0d want 0", occ); end
  endtask

  task automatic test_stall_collapse();
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1; up_if.data = 8'h11; #1;
    n_checks++; if (up_if.ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready0: got %b want 1", up_if.ready); end
    tick();
    up_if.valid = 1'b0; tick();
    up_if.valid = 1'b1; up_if.data = 8'h22; #1;
    n_checks++; if (up_if.ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready2: got %b want 1", up_if.ready); end
    tick();
    up_if.valid = 1'b0; tick();
    n_checks++; if (dn_if.valid !== 1'b1 || dn_if.data !== 8'h11) begin n_fail++; $display("FAIL stall_head: got %b/%h want 1/11", dn_if.valid, dn_if.data); end
    n_checks++; if (occ !== 2'd2) begin n_fail++; $display("FAIL stall_occ2: got %0d want 2", occ); end
    n_checks++; if (up_if.ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_occ2: got %b want 1", up_if.ready); end
    up_if.valid = 1'b1; up_if.data = 8'h33; tick();
    up_if.data = 8'h44; #1;
    n_checks++; if (up_if.ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_full: got %b want 0", up_if.ready); end
    n_checks++; if (occ !== 2'd3) begin n_fail++; $display("FAIL stall_occ3: got %0d want 3", occ); end
    n_checks++; if (dn_if.data !== 8'h11) begin n_fail++; $display("FAIL stall_hold: got %h want 11", dn_if.data); end
    up_if.valid = 1'b0; dn_if.ready = 1'b1; #1;
    n_checks++; if (dn_if.data !== 8'h11) begin n_fail++; $display("FAIL stall_drain0: got %h want 11", dn_if.data); end
    tick();
    n_checks++; if (dn_if.valid !== 1'b1 || dn_if.data !== 8'h22) begin n_fail++; $display("FAIL stall_drain1: got %b/%h want 1/22", dn_if.valid, dn_if.data); end
    tick();
    n_checks++; if (dn_if.valid !== 1'b1 || dn_if.data !== 8'h33) begin n_fail++; $display("FAIL stall_drain2: got %b/%h want 1/33", dn_if.valid, dn_if.data); end
    tick();
    n_checks++; if (dn_if.valid !== 1'b0 || occ !== 2'd0) begin n_fail++; $display("FAIL stall_empty: got %b/%0d want 0/0", dn_if.valid, occ); end
  endtask

  task automatic test_full_drain();
    logic [7:0] exp_d;
    dn_if.ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      up_if.valid = 1'b1; up_if.data = 8'(8'hA0 + k); tick();
    end
    up_if.valid = 1'b0; #1;
    n_checks++; if (occ !== 2'd3) begin n_fail++; $display("FAIL full_occ: got %0d want 3", occ); end
    n_checks++; if (up_if.ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_stalled: got %b want 0", up_if.ready); end
    dn_if.ready = 1'b1; up_if.valid = 1'b1; up_if.data = 8'hA3; #1;
    n_checks++; if (up_if.ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_drain: got %b want 1", up_if.ready); end
    n_checks++; if (dn_if.valid !== 1'b1 || dn_if.data !== 8'hA0) begin n_fail++; $display("FAIL full_head: got %b/%h want 1/a0", dn_if.valid, dn_if.data); end
    tick();
    up_if.valid = 1'b0;
    n_checks++; if (occ !== 2'd3) begin n_fail++; $display("FAIL full_occ_after: got %0d want 3", occ); end
    for (int k = 1; k < 4; k++) begin
      exp_d = 8'(8'hA0 + k);
      n_checks++; if (dn_if.valid !== 1'b1 || dn_if.data !== exp_d) begin n_fail++; $display("FAIL full_drain k=%0d: got %b/%h want 1/%h", k, dn_if.valid, dn_if.data, exp_d); end
      tick();
    end
    n_checks++; if (dn_if.valid !== 1'b0 || occ !== 2'd0) begin n_fail++; $display("FAIL full_empty: got %b/%0d want 0/0", dn_if.valid, occ); end
  endtask

  task automatic test_flush();
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1; up_if.data = 8'h66; tick();
    up_if.data = 8'h77; tick();
    up_if.valid = 1'b0;
    n_checks++; if (occ !== 2'd2) begin n_fail++; $display("FAIL flush_pre_occ: got %0d want 2", occ); end
    flush_in = 1'b1; up_if.valid = 1'b1; up_if.data = 8'h55; #1;
    n_checks++; if (up_if.ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", up_if.ready); end
    tick();
    flush_in = 1'b0; up_if.valid = 1'b0;
    n_checks++; if (dn_if.valid !== 1'b0 || occ !== 2'd0) begin n_fail++; $display("FAIL flush_after: got %b/%0d want 0/0", dn_if.valid, occ); end
    dn_if.ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (dn_if.valid !== 1'b0) begin n_fail++; $display("FAIL flush_leak k=%0d: got %b/%h want 0", k, dn_if.valid, dn_if.data); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    dn_if.ready = 1'b1;
    up_if.valid = 1'b1; up_if.data = 8'h12; tick();
    up_if.data = 8'h34; tick();
    up_if.valid = 1'b0; tick();
    n_checks++; if (dn_if.valid !== 1'b1 || dn_if.data !== 8'h12) begin n_fail++; $display("FAIL arst_pre: got %b/%h want 1/12", dn_if.valid, dn_if.data); end
    #2 rst_n_in = 1'b0;
    #1;
    n_checks++; if (dn_if.valid !== 1'b0 || dn_if.data !== 8'h00 || occ !== 2'd0) begin n_fail++; $display("FAIL arst_clear: got %b/%h/%0d want 0/00/0", dn_if.valid, dn_if.data, occ); end
    @(posedge clk_in);
    #2 rst_n_in = 1'b1;
    up_if.valid = 1'b1; up_if.data = 8'h7E; #1;
    n_checks++; if (up_if.ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %b want 1", up_if.ready); end
    tick();
    up_if.valid = 1'b0; tick();
    n_checks++; if (dn_if.valid !== 1'b0) begin n_fail++; $display("FAIL arst_early: got %b want 0", dn_if.valid); end
    tick();
    n_checks++; if (dn_if.valid !== 1'b1 || dn_if.data !== 8'h7E || occ !== 2'd1) begin n_fail++; $display("FAIL arst_7e: got %b/%h/%0d want 1/7e/1", dn_if.valid, dn_if.data, occ); end
    tick();
  endtask

  task automatic test_random();
    logic [7:0] sb[$];
    logic [7:0] exp_d;
    xfer_t      prev;
    logic       prev_rdy;
    int         sent = 0;
    int         cyc = 0;
    int         occ_m = 0;
    prev = '0; prev_rdy = 1'b1;
    while ((sent < 10000 || sb.size() > 0) && cyc < 60000) begin
      up_if.valid = (sent < 10000) && ($urandom_range(3) != 0);
      up_if.data  = 8'($urandom);
      dn_if.ready = (sent >= 10000) || ($urandom_range(3) != 0);
      #1;
      if (prev.valid && !prev_rdy) begin
        n_checks++; if (dn_if.valid !== 1'b1 || dn_if.data !== prev.data) begin n_fail++; $display("FAIL rand_hold cyc=%0d: got %b/%h want 1/%h", cyc, dn_if.valid, dn_if.data, prev.data); end
      end
      n_checks++; if (occ !== CW'(occ_m) || occ > 2'd3) begin n_fail++; $display("FAIL rand_occ cyc=%0d: got %0d want %0d", cyc, occ, occ_m); end
      if (dn_if.valid && dn_if.ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL rand_extra cyc=%0d: got %h want none", cyc, dn_if.data);
        end else begin
          exp_d = sb.pop_front();
          if (dn_if.data !== exp_d) begin n_fail++; $display("FAIL rand_data cyc=%0d: got %h want %h", cyc, dn_if.data, exp_d); end
        end
        occ_m--;
      end
      if (up_if.valid && up_if.ready) begin
        sb.push_back(up_if.data);
        sent++;
        occ_m++;
      end
      prev.valid = dn_if.valid; prev.data = dn_if.data; prev_rdy = dn_if.ready;
      tick();
      cyc++;
    end
    up_if.valid = 1'b0;
    n_checks++; if (sent != 10000 || sb.size() != 0) begin n_fail++; $display("FAIL rand_complete: got sent=%0d pending=%0d want 10000/0", sent, sb.size()); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall_collapse();
    test_full_drain();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
